// File: rtl/afe_spi_pkg.sv
// Shared constants, FIFO entry layout and saturating-increment helper for the AFE SPI receiver.
// AFE_SPI_RX_TIMESTAMP_EN adds a 32-bit commit timestamp to every FIFO entry.
package afe_spi_pkg;

  localparam int AFE_WORD_WIDTH = 16;
  localparam int AFE_FIFO_AW    = 3;
  localparam int AFE_TS_W       = 32;

  // Entry layout at the default word width; the top packs the same order {ts, word}.
  typedef struct packed {
`ifdef AFE_SPI_RX_TIMESTAMP_EN
    logic [AFE_TS_W-1:0]       ts;
`endif
    logic [AFE_WORD_WIDTH-1:0] word;
  } afe_fifo_entry_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/afe_spi_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is visible whenever the FIFO is non-empty.
// A push while full is accepted only when a pop happens in the same cycle.
module afe_spi_rx_fifo #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_eff, pop_eff;

  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == (AW+1)'(DEPTH));
  assign pop_eff  = pop_i & ~empty_o;
  assign push_eff = push_i & (~full_o | pop_eff);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_eff) wptr_d = wptr_q + 1'b1;
    if (pop_eff)  rptr_d = rptr_q + 1'b1;
    unique case ({push_eff, pop_eff})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_eff) mem_q[wptr_q] <= data_i;
  end

  // Gate the head so the read port is all-zero while empty, including after reset.
  assign data_o  = empty_o ? '0 : mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/afe_spi_rx.sv
// Receiver for the write-only AFE attenuator SPI link: oversamples clock/SDI/LE, rebuilds latched
// words into a FWFT FIFO and counts framing/overflow errors. AFE_SPI_RX_TIMESTAMP_EN adds rdTimestamp.
module afe_spi_rx import afe_spi_pkg::*; #(
  parameter int WORD_WIDTH  = AFE_WORD_WIDTH,
  parameter int FIFO_AW     = AFE_FIFO_AW,
  parameter int SYNC_STAGES = 3,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                  sysClk,
  input  logic                  sysReset,
  input  logic                  spiClk,
  input  logic                  spiSdi,
  input  logic                  spiLe,
  input  logic                  statusClear,
  output logic [WORD_WIDTH-1:0] rdData,
  output logic                  rdValid,
  input  logic                  rdReady,
  output logic [FIFO_AW:0]      fifoCount,
  output logic [CNT_WIDTH-1:0]  frameErrCount,
`ifdef AFE_SPI_RX_TIMESTAMP_EN
  output logic [31:0]           rdTimestamp,
`endif
  output logic [CNT_WIDTH-1:0]  overflowCount
);

  localparam int BCW = $clog2(WORD_WIDTH + 2);
  localparam logic [BCW-1:0] BC_FULL = BCW'(WORD_WIDTH);
  localparam logic [BCW-1:0] BC_SAT  = BCW'(WORD_WIDTH + 1);
  localparam logic [31:0]    CNT_MAX = 32'((64'd1 << CNT_WIDTH) - 64'd1);
`ifdef AFE_SPI_RX_TIMESTAMP_EN
  localparam int TS_W = AFE_TS_W;
`else
  localparam int TS_W = 0;
`endif
  localparam int ENTRY_W = WORD_WIDTH + TS_W;

  // SYNC_STAGES must be at least 2; all three lines share identical chains to stay aligned.
  logic [SYNC_STAGES-1:0] clk_sync_q, sdi_sync_q, le_sync_q;
  logic                   clk_prev_q, le_prev_q;
  logic                   clk_s, sdi_s, le_s;
  logic                   clk_rise, le_rise, shift_en;

  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      clk_sync_q <= '0;
      sdi_sync_q <= '0;
      le_sync_q  <= '0;
      clk_prev_q <= 1'b0;
      le_prev_q  <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], spiClk};
      sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], spiSdi};
      le_sync_q  <= {le_sync_q[SYNC_STAGES-2:0], spiLe};
      clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
      le_prev_q  <= le_sync_q[SYNC_STAGES-1];
    end
  end

  assign clk_s    = clk_sync_q[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
  assign le_s     = le_sync_q[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_prev_q;
  assign le_rise  = le_s & ~le_prev_q;
  // A clock edge coinciding with the LE edge still belongs to the frame being latched.
  assign shift_en = clk_rise & (~le_s | le_rise);

  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [BCW-1:0]        bitcnt_q, bitcnt_d, bitcnt_upd;
  logic                  commit_ok, frame_err;
  logic [ENTRY_W-1:0]    entry_d, push_entry_q;
  logic                  push_q;

`ifdef AFE_SPI_RX_TIMESTAMP_EN
  logic [31:0] ts_q;

  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) ts_q <= '0;
    else          ts_q <= ts_q + 32'd1;
  end

  assign entry_d = {ts_q, shift_d};
`else
  assign entry_d = shift_d;
`endif

  always_comb begin
    shift_d    = shift_q;
    bitcnt_upd = bitcnt_q;
    if (shift_en) begin
      shift_d = {shift_q[WORD_WIDTH-2:0], sdi_s};
      if (bitcnt_q != BC_SAT) bitcnt_upd = bitcnt_q + 1'b1;
    end
    commit_ok = le_rise && (bitcnt_upd == BC_FULL);
    frame_err = le_rise && !commit_ok;
    bitcnt_d  = le_rise ? '0 : bitcnt_upd;
  end

  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      shift_q      <= '0;
      bitcnt_q     <= '0;
      push_q       <= 1'b0;
      push_entry_q <= '0;
    end else begin
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      push_q   <= commit_ok;
      if (commit_ok) push_entry_q <= entry_d;
    end
  end

  // Read port: the word at rdData is consumed at the clock edge where rdValid && rdReady are both
  // high; rdData is stable while rdValid is high and rdReady is low.
  logic [ENTRY_W-1:0] fifo_rdata;
  logic               fifo_full, fifo_empty;
  logic               ovf_inc;

  afe_spi_rx_fifo #(
    .DW (ENTRY_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk_i   (sysClk),
    .rst_i   (sysReset),
    .push_i  (push_q),
    .data_i  (push_entry_q),
    .pop_i   (rdReady),
    .data_o  (fifo_rdata),
    .count_o (fifoCount),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rdValid = ~fifo_empty;
  assign rdData  = fifo_rdata[WORD_WIDTH-1:0];
`ifdef AFE_SPI_RX_TIMESTAMP_EN
  assign rdTimestamp = fifo_rdata[ENTRY_W-1 -: 32];
`endif
  assign ovf_inc = push_q & fifo_full & ~(rdReady & rdValid);

  logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;

  // Clear has priority over a same-cycle increment.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    ovf_cnt_d   = ovf_cnt_q;
    if (frame_err) frame_cnt_d = CNT_WIDTH'(sat_inc(32'(frame_cnt_q), CNT_MAX));
    if (ovf_inc)   ovf_cnt_d   = CNT_WIDTH'(sat_inc(32'(ovf_cnt_q), CNT_MAX));
    if (statusClear) begin
      frame_cnt_d = '0;
      ovf_cnt_d   = '0;
    end
  end

  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      frame_cnt_q <= '0;
      ovf_cnt_q   <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      ovf_cnt_q   <= ovf_cnt_d;
    end
  end

  assign frameErrCount = frame_cnt_q;
  assign overflowCount = ovf_cnt_q;

endmodule

// File: tb/tb_afe_spi_rx.sv
// Self-checking bench for afe_spi_rx: SPI driver tasks, scoreboard queue of expected words,
// error-counter model and a final report.
module tb_afe_spi_rx;

  localparam int W     = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int SS    = 3;
  localparam int HALF  = 4;
  localparam int CMAX  = 255;

  logic          sysClk = 1'b0;
  logic          sysReset, spiClk, spiSdi, spiLe, statusClear, rdReady;
  logic [W-1:0]  rdData;
  logic          rdValid;
  logic [AW:0]   fifoCount;
  logic [7:0]    frameErrCount, overflowCount;
`ifdef AFE_SPI_RX_TIMESTAMP_EN
  logic [31:0]   rdTimestamp;
  logic [31:0]   last_ts;
  logic          ts_seen = 1'b0;
`endif

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int err_m    = 0;
  int ovf_m    = 0;

  afe_spi_rx dut (
    .sysClk        (sysClk),
    .sysReset      (sysReset),
    .spiClk        (spiClk),
    .spiSdi        (spiSdi),
    .spiLe         (spiLe),
    .statusClear   (statusClear),
    .rdData        (rdData),
    .rdValid       (rdValid),
    .rdReady       (rdReady),
    .fifoCount     (fifoCount),
    .frameErrCount (frameErrCount),
`ifdef AFE_SPI_RX_TIMESTAMP_EN
    .rdTimestamp   (rdTimestamp),
`endif
    .overflowCount (overflowCount)
  );

  // ---------------- clock / reset ----------------
  always #5 sysClk = ~sysClk;

  task automatic do_reset(input int cycles);
    @(negedge sysClk);
    sysReset = 1'b1;
    repeat (cycles) @(negedge sysClk);
    sysReset = 1'b0;
`ifdef AFE_SPI_RX_TIMESTAMP_EN
    ts_seen = 1'b0;
`endif
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // ---------------- drivers ----------------
  task automatic send_bits(input logic [31:0] data, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      @(negedge sysClk);
      spiSdi = data[i];
      repeat (HALF - 1) @(negedge sysClk);
      spiClk = 1'b1;
      repeat (HALF) @(negedge sysClk);
      spiClk = 1'b0;
    end
  endtask

  task automatic pulse_le();
    @(negedge sysClk);
    spiLe = 1'b1;
    repeat (HALF) @(negedge sysClk);
    spiLe = 1'b0;
    repeat (HALF) @(negedge sysClk);
  endtask

  task automatic le_only();
    @(negedge sysClk);
    spiLe = 1'b1;
    repeat (3) @(negedge sysClk);
    spiLe = 1'b0;
    repeat (3) @(negedge sysClk);
  endtask

  // Valid frame with rdReady low: the model queue occupancy decides accept or drop.
  task automatic good_frame(input logic [W-1:0] data);
    send_bits(32'(data), W);
    if (exp_q.size() < DEPTH) exp_q.push_back(data);
    else ovf_m++;
    pulse_le();
  endtask

  task automatic err_inc();
    err_m = (err_m >= CMAX) ? CMAX : err_m + 1;
  endtask

  task automatic settle();
    repeat (10) @(negedge sysClk);
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    @(posedge sysClk);
    #1 rdReady = 1'b1;
    while (exp_q.size() != 0 && cyc < 4 * DEPTH + 10) begin
      @(posedge sysClk);
      cyc++;
    end
    #1 rdReady = 1'b0;
    check("drain_left", 32'(exp_q.size()), 32'd0);
    @(negedge sysClk);
    check("drain_fifo_count", 32'(fifoCount), 32'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge sysClk) begin
    if (!sysReset && rdValid && rdReady) begin
      if (exp_q.size() == 0) check("sb_extra_word", 32'(rdData), 32'hFFFF_FFFF);
      else check("sb_word", 32'(rdData), 32'(exp_q.pop_front()));
`ifdef AFE_SPI_RX_TIMESTAMP_EN
      if (ts_seen) check("ts_increasing", 32'(rdTimestamp > last_ts), 32'd1);
      last_ts = rdTimestamp;
      ts_seen = 1'b1;
`endif
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    logic [W-1:0] d;
    sysReset    = 1'b1;
    spiClk      = 1'b0;
    spiSdi      = 1'b0;
    spiLe       = 1'b0;
    statusClear = 1'b0;
    rdReady     = 1'b0;
    do_reset(3);
    @(negedge sysClk);
    check("rst_rdvalid", 32'(rdValid), 32'd0);
    check("rst_rddata", 32'(rdData), 32'd0);
    check("rst_fifo_count", 32'(fifoCount), 32'd0);
    check("rst_frame_err", 32'(frameErrCount), 32'd0);
    check("rst_overflow", 32'(overflowCount), 32'd0);

    // Single good word and its latency from the LE drive
    send_bits(32'hA5C3, W);
    @(negedge sysClk);
    spiLe = 1'b1;
    lat = 0;
    while (!rdValid && lat < 12) begin
      @(negedge sysClk);
      lat++;
    end
    check("t1_latency", 32'(lat), 32'(SS + 2));
    exp_q.push_back(16'hA5C3);
    @(negedge sysClk);
    spiLe = 1'b0;
    repeat (4) @(negedge sysClk);
    check("t1_rddata", 32'(rdData), 32'hA5C3);
    check("t1_fifo_count", 32'(fifoCount), 32'd1);
    check("t1_frame_err", 32'(frameErrCount), 32'(err_m));
    check("t1_overflow", 32'(overflowCount), 32'(ovf_m));
    drain();

    // Short and long frames, then a good one
    send_bits(32'h0000_5A5A, 15);
    pulse_le();
    err_inc();
    send_bits(32'h0001_3C3C, 17);
    pulse_le();
    err_inc();
    settle();
    check("t2_frame_err", 32'(frameErrCount), 32'(err_m));
    check("t2_fifo_count", 32'(fifoCount), 32'd0);
    good_frame(16'h1234);
    settle();
    check("t2_good_count", 32'(fifoCount), 32'd1);
    drain();

    // Ten frames into an eight-deep FIFO with no reader
    for (int i = 0; i < 10; i++) begin
      d = W'($urandom_range(0, 65535));
      good_frame(d);
    end
    settle();
    check("t3_fifo_count", 32'(fifoCount), 32'(DEPTH));
    check("t3_overflow", 32'(overflowCount), 32'(ovf_m));

    // Push into a full FIFO in the same cycle as a pop
    d = W'($urandom_range(0, 65535));
    send_bits(32'(d), W);
    exp_q.push_back(d);
    @(negedge sysClk);
    spiLe = 1'b1;
    repeat (SS + 1) @(posedge sysClk);
    #1 rdReady = 1'b1;
    @(posedge sysClk);
    #1 rdReady = 1'b0;
    repeat (3) @(negedge sysClk);
    spiLe = 1'b0;
    settle();
    check("t4_overflow", 32'(overflowCount), 32'(ovf_m));
    check("t4_fifo_count", 32'(fifoCount), 32'(DEPTH));
    drain();

    // Reset in the middle of a frame
    send_bits(32'hBEEF >> 9, 7);
    do_reset(3);
    err_m = 0;
    ovf_m = 0;
    send_bits(32'hBEEF & 32'h1FF, 9);
    pulse_le();
    err_inc();
    settle();
    check("t5_frame_err", 32'(frameErrCount), 32'(err_m));
    check("t5_fifo_count", 32'(fifoCount), 32'd0);
    check("t5_rdvalid", 32'(rdValid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      d = W'($urandom_range(0, 65535));
      good_frame(d);
    end
    settle();
    check("t5_good_count", 32'(fifoCount), 32'd3);
    drain();

    // Saturation of the frame-error counter, then clear
    for (int i = 0; i < 260; i++) begin
      le_only();
      err_inc();
    end
    settle();
    check("t6_saturated", 32'(frameErrCount), 32'(err_m));
    @(negedge sysClk);
    statusClear = 1'b1;
    @(negedge sysClk);
    statusClear = 1'b0;
    err_m = 0;
    ovf_m = 0;
    @(negedge sysClk);
    check("t6_cleared", 32'(frameErrCount), 32'd0);
    check("t6_ovf_cleared", 32'(overflowCount), 32'd0);

    // Clear coinciding with an error increment
    @(negedge sysClk);
    spiLe = 1'b1;
    repeat (SS) @(posedge sysClk);
    #1 statusClear = 1'b1;
    @(posedge sysClk);
    #1 statusClear = 1'b0;
    repeat (3) @(negedge sysClk);
    spiLe = 1'b0;
    settle();
    check("t6_clear_wins", 32'(frameErrCount), 32'd0);
    le_only();
    err_inc();
    settle();
    check("t6_after_clear", 32'(frameErrCount), 32'(err_m));

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    check("watchdog", 32'd0, 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
